// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - Op encodings (3-bit; 4-bit when MDU_MADD_EN adds the accumulate ops)
//   - FSM state enum
//   - op_latency(): maps an op code onto its latency class
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP   = op_t'(0);
  localparam op_t OP_MULT  = op_t'(1);
  localparam op_t OP_MULTU = op_t'(2);
  localparam op_t OP_DIV   = op_t'(3);
  localparam op_t OP_DIVU  = op_t'(4);
  localparam op_t OP_MTHI  = op_t'(5);
  localparam op_t OP_MTLO  = op_t'(6);
`ifdef MDU_MADD_EN
  localparam op_t OP_MADD  = op_t'(8);
  localparam op_t OP_MADDU = op_t'(9);
  localparam op_t OP_MSUB  = op_t'(10);
  localparam op_t OP_MSUBU = op_t'(11);
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // LAT_MOVE ops complete at the issue edge; LAT_NONE ops do nothing.
  typedef enum logic [1:0] {LAT_NONE, LAT_MOVE, LAT_MULT, LAT_DIV} lat_class_e;

  function automatic lat_class_e op_latency(input op_t op);
    lat_class_e cls;
    cls = LAT_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = LAT_MULT;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = LAT_MULT;
`endif
      OP_DIV, OP_DIVU:   cls = LAT_DIV;
      OP_MTHI, OP_MTLO:  cls = LAT_MOVE;
      default:           cls = LAT_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// mdu_latency_counter: loadable down-counter with a zero flag.
// Ports:
//   Clk, Reset   - clock, synchronous active-low reset
//   i_load/i_val - load i_val (takes priority over decrement)
//   i_dec        - decrement by one
//   o_zero       - counter value is zero
module mdu_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   Clk, Reset - clock, synchronous active-low reset
//   Start, Op  - single-cycle request and op code (mdu_pkg encodings)
//   A, B       - operands rs / rt
//   Busy       - registered, high for N cycles after an accepted mult/div
//   HI, LO     - registered result registers
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_multicycle
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OP_W-1:0]  Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi, r_lo, r_a, r_b;
  op_t              r_op;

  lat_class_e       w_cls;
  logic             w_issue, w_cnt_zero, w_dec;
  logic [CNT_W-1:0] w_load_val;

  assign w_cls      = op_latency(Op);
  assign w_issue    = (r_state == ST_IDLE) && Start &&
                      ((w_cls == LAT_MULT) || (w_cls == LAT_DIV));
  assign w_load_val = (w_cls == LAT_DIV) ? CNT_W'(DIV_CYCLES - 1)
                                         : CNT_W'(MULT_CYCLES - 1);
  assign w_dec      = (r_state == ST_RUN) && !w_cnt_zero;

  mdu_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_load (w_issue),
    .i_val  (w_load_val),
    .i_dec  (w_dec),
    .o_zero (w_cnt_zero)
  );

  // Results are combinational from the latched operands; only the commit
  // edge matters.
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Divisors are forced to 1 for B==0 (result discarded anyway) and for the
  // signed overflow case, where MOST_NEG/1 gives exactly quotient=MOST_NEG,
  // remainder=0 without ever evaluating the overflowing division.
  logic                    w_div_ovf;
  logic [WIDTH-1:0]        w_divu_b, w_divs_b, w_quo_u, w_rem_u;
  logic signed [WIDTH-1:0] w_quo_s, w_rem_s;
  assign w_div_ovf = (r_a == MOST_NEG) && (r_b == '1);
  assign w_divu_b  = (r_b == '0) ? WIDTH'(1) : r_b;
  assign w_divs_b  = ((r_b == '0) || w_div_ovf) ? WIDTH'(1) : r_b;
  assign w_quo_u   = r_a / w_divu_b;
  assign w_rem_u   = r_a % w_divu_b;
  assign w_quo_s   = $signed(r_a) / $signed(w_divs_b);
  assign w_rem_s   = $signed(r_a) % $signed(w_divs_b);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            case (w_cls)
              LAT_MULT, LAT_DIV: begin
                r_a     <= A;
                r_b     <= B;
                r_op    <= Op;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
              end
              LAT_MOVE: begin
                if (Op == OP_MTHI) r_hi <= A;
                else               r_lo <= A;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Start is not looked at here: requests during RUN are dropped.
          if (w_cnt_zero) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            case (r_op)
              OP_MULT:  {r_hi, r_lo} <= w_prod_s;
              OP_MULTU: {r_hi, r_lo} <= w_prod_u;
              OP_DIV:   if (r_b != '0) begin r_lo <= w_quo_s; r_hi <= w_rem_s; end
              OP_DIVU:  if (r_b != '0) begin r_lo <= w_quo_u; r_hi <= w_rem_u; end
`ifdef MDU_MADD_EN
              OP_MADD:  {r_hi, r_lo} <= {r_hi, r_lo} + w_prod_s;
              OP_MADDU: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod_u;
              OP_MSUB:  {r_hi, r_lo} <= {r_hi, r_lo} - w_prod_s;
              OP_MSUBU: {r_hi, r_lo} <= {r_hi, r_lo} - w_prod_u;
`endif
              default: ;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
